// File: rtl/adder_beq_pkg.sv
// Shared types and constants for the branch-target adder.
// No logic; consumed by adder_beq and its carry-lookahead sub-module.
// No flow control: values only.
package adder_beq_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] addr_t;

   // Value held on the branch target while the core is in reset.
   localparam addr_t ADDR_RST = '0;

endpackage

// File: rtl/adder_beq_cla_adder.sv
// Two-level carry-lookahead adder: per-group G/P, then group carries from cin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs continuously.
module cla_adder
   import adder_beq_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int GROUP_W = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NGRP = WIDTH / GROUP_W;

   // Groups must tile the operand exactly, otherwise top bits would be dropped.
   if ((WIDTH % GROUP_W) != 0) begin : g_bad_group
      $error("cla_adder: GROUP_W must divide WIDTH");
   end

   logic [WIDTH-1:0] bit_g;
   logic [WIDTH-1:0] bit_p;
   logic [NGRP-1:0]  grp_g;
   logic [NGRP-1:0]  grp_p;
   logic [NGRP:0]    grp_c;

   assign bit_g = a & b;
   assign bit_p = a ^ b;

   assign grp_c[0] = cin;
   assign cout     = grp_c[NGRP];

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      logic                gg;
      logic                pp;
      logic                la_c;
      logic [GROUP_W-1:0]  grp_sum;

      // Group generate/propagate: does this group create a carry, or pass one through.
      always_comb begin
         gg = 1'b0;
         pp = 1'b1;
         for (int i = 0; i < GROUP_W; i++) begin
            gg = bit_g[k*GROUP_W + i] | (bit_p[k*GROUP_W + i] & gg);
            pp = pp & bit_p[k*GROUP_W + i];
         end
      end

      assign grp_g[k] = gg;
      assign grp_p[k] = pp;

      // Lookahead carry out of group k, built only from group G/P and cin (no chain through grp_c).
      always_comb begin
         logic pchain;
         la_c   = 1'b0;
         pchain = 1'b1;
         for (int j = k; j >= 0; j--) begin
            la_c   = la_c | (grp_g[j] & pchain);
            pchain = pchain & grp_p[j];
         end
         la_c = la_c | (pchain & cin);
      end

      assign grp_c[k+1] = la_c;

      // Sum bits of the group, carried locally from the group's lookahead carry-in.
      always_comb begin
         logic c;
         c = grp_c[k];
         for (int i = 0; i < GROUP_W; i++) begin
            grp_sum[i] = bit_p[k*GROUP_W + i] ^ c;
            c          = bit_g[k*GROUP_W + i] | (bit_p[k*GROUP_W + i] & c);
         end
      end

      assign sum[k*GROUP_W +: GROUP_W] = grp_sum;
   end

endmodule

// File: rtl/adder_beq.sv
// Branch target = Addr + Extended_imm (mod 2^XLEN), registered for next-PC select.
// Latency: 1 cycle, one new result every cycle; async active-high reset clears it.
// Backpressure: none, evaluates every cycle. Define ADDER_BEQ_ASSERT_EN for checks.
module adder_beq
   import adder_beq_pkg::*;
#(
   parameter int XLEN    = adder_beq_pkg::XLEN,
   parameter int GROUP_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] Addr,
   input  logic [XLEN-1:0] Extended_imm,
   output logic [XLEN-1:0] NextAddr
);

   logic [XLEN-1:0] target_sum;
   logic            unused_cout;

   // Carry-out is meaningless for an address wrap and is intentionally dropped.
   cla_adder #(
      .WIDTH   (XLEN),
      .GROUP_W (GROUP_W)
   ) u_cla (
      .a    (Addr),
      .b    (Extended_imm),
      .cin  (1'b0),
      .sum  (target_sum),
      .cout (unused_cout)
   );

   // Target register; reset wins immediately, in-flight result is discarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         NextAddr <= XLEN'(ADDR_RST);
      end else begin
         NextAddr <= target_sum;
      end
   end

`ifdef ADDER_BEQ_ASSERT_EN
   logic [XLEN-1:0] chk_sum;
   assign chk_sum = Addr + Extended_imm;

   // Registered target must equal the previous cycle's truncated sum.
   a_sum: assert property (@(posedge clk) disable iff (rst)
      !$past(rst) |-> (NextAddr == $past(chk_sum)));

   // Output is cleared whenever reset is held.
   a_rst: assert property (@(posedge clk) rst |-> (NextAddr == '0));

   // Misaligned targets are legal arithmetic but worth flagging.
   always @(posedge clk) begin
      if (!rst && (NextAddr[1:0] != 2'b00)) begin
         $warning("adder_beq: misaligned branch target %h", NextAddr);
      end
   end
`endif

endmodule

// File: tb/tb_adder_beq.sv
// Self-checking bench for adder_beq: directed vectors plus random operands.
// A history-based model predicts NextAddr and is compared every cycle.
// Literal expectations pin both the DUT and the model.
module tb_adder_beq;

   logic        clk;
   logic        rst;
   logic [31:0] Addr;
   logic [31:0] Extended_imm;
   logic [31:0] NextAddr;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   adder_beq dut (
      .clk          (clk),
      .rst          (rst),
      .Addr         (Addr),
      .Extended_imm (Extended_imm),
      .NextAddr     (NextAddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: what the inputs looked like at the most recent rising edge.
   logic        hist_rst;
   logic [31:0] hist_sum;
   logic [31:0] model_exp;

   always @(posedge clk) begin
      hist_rst <= rst;
      hist_sum <= 32'((64'(Addr) + 64'(Extended_imm)) % 64'h1_0000_0000);
   end

   // Reset now, or at the last edge, means zero; otherwise the last sampled sum.
   assign model_exp = (rst || (hist_rst !== 1'b0)) ? 32'h0 : hist_sum;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, 2 time units after the edge.
   always begin
      @(posedge clk);
      #2;
      if (cmp_en) chk("model", NextAddr, model_exp);
   end

   task automatic step_check(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
      @(negedge clk);
      Addr         = a;
      Extended_imm = b;
      @(posedge clk);
      #2;
      chk(name, NextAddr, exp);
   endtask

   initial begin
      rst          = 1'b1;
      Addr         = 32'd5;
      Extended_imm = 32'd10;
      cmp_en       = 1'b1;

      // Held in reset across several edges.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         chk("reset_hold", NextAddr, 32'h0);
      end

      // Release reset; first edge loads 5 + 10.
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #2;
      chk("basic_5_10", NextAddr, 32'd15);
      chk("pin_model_15", model_exp, 32'd15);

      step_check("basic_10_2",  32'd10,         32'd2,          32'd12);
      step_check("neg_offset",  32'h0000_0100,  32'hFFFF_FFF8,  32'h0000_00F8);
      chk("pin_model_neg", model_exp, 32'h0000_00F8);
      step_check("wrap",        32'hFFFF_FFFC,  32'h0000_0008,  32'h0000_0004);
      step_check("carry_chain", 32'h7FFF_FFFF,  32'h0000_0001,  32'h8000_0000);
      step_check("all_ones",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
      step_check("odd_bit0",    32'h0000_0001,  32'h0000_0000,  32'h0000_0001);
      step_check("group_carry", 32'h0000_000F,  32'h0000_0001,  32'h0000_0010);

      // Async reset between edges while the output holds 12.
      step_check("pre_rst_12",  32'd10,         32'd2,          32'd12);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_clear", NextAddr, 32'h0);
      Addr         = 32'h0000_1000;
      Extended_imm = 32'h0000_0024;
      @(posedge clk);
      #2;
      chk("rst_still_held", NextAddr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #2;
      chk("first_after_rst", NextAddr, 32'h0000_1024);
      chk("pin_model_1024", model_exp, 32'h0000_1024);

      // Random operand pairs, checked by the every-cycle compare.
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         Addr         = $urandom;
         Extended_imm = $urandom;
      end
      @(posedge clk);
      #3;
      cmp_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #50000;
      failures++;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
